stump_io_responder: RTL

- Memory-mapped peripheral that answers Stump CPU bus cycles (address, write data, mem_wen, mem_ren) with read data.
- Sits beside system RAM on the Stump memory bus; the top-level data_in mux selects its read data when sel is high.
- Provides a byte transmit FIFO with a valid/ready output, a single-entry receive holding register, and a reload down-counter timer.

---
 rtl/stump_io_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/stump_io_responder.sv
// Stump bus I/O responder: TX byte FIFO, RX holding register and reload timer in an 8-word window.
// Optional `STUMP_IRQ_EN adds a registered irq output and CTRL[3:2] interrupt enables.
module stump_io_responder #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    input  logic        mem_wen,
    input  logic        mem_ren,
    output logic [15:0] rdata,
    output logic        sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
`ifdef STUMP_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_TX     = 3'd1;
    localparam logic [2:0] OFF_RX     = 3'd2;
    localparam logic [2:0] OFF_LOAD   = 3'd3;
    localparam logic [2:0] OFF_COUNT  = 3'd4;
    localparam logic [2:0] OFF_CTRL   = 3'd5;

    logic [2:0]       offset;
    logic             wr;
    logic             rd;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;
    logic             push_req;
    logic             push_ok;
    logic             pop;
    logic             ovf;
    logic             ovf_set;

    logic [7:0]       rx_hold;
    logic             rx_full;
    logic             rx_take;
    logic             rx_rd;

    logic [15:0]      timer_load;
    logic [15:0]      timer_count;
    logic             timer_en;
    logic             timer_flag;
    logic             flag_set;
    logic             load_wr;
    logic             ctrl_wr;
    logic             status_clr;

`ifdef STUMP_IRQ_EN
    logic [1:0]       irq_en;
`endif

    // Bus decode: a write always wins over a read, so a combined cycle has no read side effect
    assign sel    = (address[15:3] == BASE_ADDR[15:3]);
    assign offset = address[2:0];
    assign wr     = sel && mem_wen;
    assign rd     = sel && mem_ren && !mem_wen;

    assign push_req   = wr && (offset == OFF_TX);
    assign rx_rd      = rd && (offset == OFF_RX);
    assign load_wr    = wr && (offset == OFF_LOAD);
    assign ctrl_wr    = wr && (offset == OFF_CTRL);
    assign status_clr = ctrl_wr && wdata[1];

    // TX FIFO: a full FIFO still takes a push when the head leaves on the same edge
    assign tx_full  = (tx_count == CNT_W'(FIFO_DEPTH));
    assign tx_empty = (tx_count == '0);
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign pop      = tx_valid && tx_ready;
    assign push_ok  = push_req && (!tx_full || pop);
    assign ovf_set  = push_req && tx_full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_count <= '0;
            ovf      <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (status_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // RX holding register: ready is sampled before the read clears it, so a
    // byte arriving while full waits one more edge
    assign rx_ready = !rx_full;
    assign rx_take  = rx_valid && rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hold <= 8'h00;
            rx_full <= 1'b0;
        end else begin
            if (rx_take) begin
                rx_hold <= rx_data;
                rx_full <= 1'b1;
            end else if (rx_rd) begin
                rx_full <= 1'b0;
            end
        end
    end

    // Timer: reloads and flags on the edge where the count is already zero
    assign flag_set = timer_en && (timer_count == 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_load  <= 16'd0;
            timer_count <= 16'd0;
            timer_flag  <= 1'b0;
            timer_en    <= 1'b0;
        end else begin
            if (load_wr) begin
                timer_load  <= wdata;
                timer_count <= wdata;
            end else if (timer_en) begin
                if (timer_count != 16'd0) begin
                    timer_count <= timer_count - 16'd1;
                end else begin
                    timer_count <= timer_load;
                end
            end
            if (flag_set) begin
                timer_flag <= 1'b1;
            end else if (status_clr) begin
                timer_flag <= 1'b0;
            end
            if (ctrl_wr) begin
                timer_en <= wdata[0];
            end
        end
    end

`ifdef STUMP_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= wdata[3:2];
            end
            irq <= (timer_flag && irq_en[0]) || (rx_full && irq_en[1]);
        end
    end
`endif

    always_comb begin
        rdata = 16'h0000;
        if (rd) begin
            case (offset)
                OFF_STATUS: rdata = {6'd0, 5'(tx_count), ovf, timer_flag, rx_full, tx_empty, tx_full};
                OFF_RX:     rdata = {8'h00, rx_hold};
                OFF_LOAD:   rdata = timer_load;
                OFF_COUNT:  rdata = timer_count;
`ifdef STUMP_IRQ_EN
                OFF_CTRL:   rdata = {12'd0, irq_en, 1'b0, timer_en};
`else
                OFF_CTRL:   rdata = {15'd0, timer_en};
`endif
                default:    rdata = 16'h0000;
            endcase
        end
    end

endmodule
